// File: rtl/move_sequencer.sv
// move_sequencer: 2048 game controller. Debounces the joystick direction,
// slides/merges the 4x4 board one line per cycle, spawns a tile at a
// pseudo-random empty cell and tracks win/lose. Owns the board state.
module move_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dir,
    input  logic        new_game,
    input  logic        board_load,
    input  logic [63:0] board_in,
    output logic [63:0] board,
    output logic        busy,
    output logic        move_done,
    output logic [15:0] move_count,
    output logic        won,
    output logic        lost
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_WAIT_RELEASE, S_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [63:0]      board_q, board_d;
    logic [15:0]      lfsr_q, lfsr_d, lfsr_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, seen;
    logic [2:0]       dir_prev_q, dir_prev_d, dir_lat_q, dir_lat_d;
    logic [1:0]       line_q, line_d;
    logic             changed_q, changed_d;
    logic [3:0]       spawn_idx_q, spawn_idx_d, spawn_cnt_q, spawn_cnt_d;
    logic             spawn_more_q, spawn_more_d;
    logic             from_move_q, from_move_d, from_init_q, from_init_d;
    logic             won_q, won_d, lost_q, lost_d, busy_q, busy_d;
    logic [15:0]      move_count_q, move_count_d;

    logic [3:0]       cells [16];
    logic [3:0]       line_idx [4];
    logic [15:0]      line_in, line_out;
    logic             any_win, board_full, has_pair, dir_valid;

    // Cell index of position pos (0 = leading end) within the given line for direction d
    function automatic logic [3:0] cell_idx(input logic [2:0] d, input logic [1:0] line,
                                            input logic [1:0] pos);
        case (d)
            3'd1:    return {pos, line};   // up: column line, rows top->bottom
            3'd2:    return {~pos, line};  // down: column line, rows bottom->top
            3'd3:    return {line, pos};   // left: row line, cols 0->3
            default: return {line, ~pos};  // right: row line, cols 3->0
        endcase
    endfunction

    // Compress toward the leading end, then merge equal pairs once each
    function automatic logic [15:0] slide_line(input logic [15:0] v);
        logic [3:0]  c [5];
        logic [15:0] o;
        logic [1:0]  n;
        logic        skip;
        for (int i = 0; i < 5; i++) c[i] = 4'd0;
        n = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] != 4'd0) begin
                c[n] = v[4*i +: 4];
                n    = n + 2'd1;
            end
        end
        o    = 16'd0;
        n    = 2'd0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[i] != 4'd0) begin
                if (c[i+1] == c[i]) begin
                    o[{n, 2'b00} +: 4] = (c[i] == 4'hF) ? 4'hF : c[i] + 4'd1;
                    skip = 1'b1;
                end else begin
                    o[{n, 2'b00} +: 4] = c[i];
                end
                n = n + 2'd1;
            end
        end
        return o;
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_cells
        assign cells[gi] = board_q[4*gi +: 4];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_line
        assign line_idx[gi]       = cell_idx(dir_lat_q, line_q, 2'(gi));
        assign line_in[4*gi +: 4] = cells[line_idx[gi]];
    end

    assign line_out  = slide_line(line_in);
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign dir_valid = (dir >= 3'd1) && (dir <= 3'd4);

    // Board status evaluated in CHECK: win tile, full board, mergeable neighbours
    always_comb begin
        any_win    = 1'b0;
        board_full = 1'b1;
        has_pair   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (cells[k] >= 4'd11) any_win = 1'b1;
            if (cells[k] == 4'd0) board_full = 1'b0;
        end
        for (int k = 0; k < 15; k++)
            if ((k % 4) != 3 && cells[k] == cells[k+1]) has_pair = 1'b1;
        for (int k = 0; k < 12; k++)
            if (cells[k] == cells[k+4]) has_pair = 1'b1;
    end

    // Next-state and datapath updates; new_game overrides everything
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        lfsr_d       = lfsr_next;
        cnt_d        = cnt_q;
        seen         = '0;
        dir_prev_d   = dir;
        dir_lat_d    = dir_lat_q;
        line_d       = line_q;
        changed_d    = changed_q;
        spawn_idx_d  = spawn_idx_q;
        spawn_cnt_d  = spawn_cnt_q;
        spawn_more_d = spawn_more_q;
        from_move_d  = from_move_q;
        from_init_d  = from_init_q;
        won_d        = won_q;
        lost_d       = lost_q;
        move_count_d = move_count_q;

        case (state_q)
            S_INIT: begin
                spawn_idx_d  = lfsr_q[3:0];
                spawn_cnt_d  = 4'd0;
                spawn_more_d = 1'b1;
                from_init_d  = 1'b1;
                from_move_d  = 1'b0;
                state_d      = S_SPAWN;
            end
            S_IDLE: begin
                if (board_load) begin
                    board_d = board_in;
                    cnt_d   = '0;
                end else begin
                    if (dir_valid && dir == dir_prev_q) seen = cnt_q + CNT_W'(1);
                    else if (dir_valid)                 seen = CNT_W'(1);
                    if (seen == CNT_TARGET) begin
                        dir_lat_d = dir;
                        line_d    = 2'd0;
                        changed_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = S_MOVE;
                    end else begin
                        cnt_d = seen;
                    end
                end
            end
            S_MOVE: begin
                for (int p = 0; p < 4; p++)
                    board_d[{line_idx[p], 2'b00} +: 4] = line_out[4*p +: 4];
                if (line_out != line_in) changed_d = 1'b1;
                line_d = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    if (changed_q || line_out != line_in) begin
                        spawn_idx_d  = lfsr_q[3:0];
                        spawn_cnt_d  = 4'd0;
                        spawn_more_d = 1'b0;
                        from_move_d  = 1'b1;
                        from_init_d  = 1'b0;
                        state_d      = S_SPAWN;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT_RELEASE;
                    end
                end
            end
            S_SPAWN: begin
                if (cells[spawn_idx_q] == 4'd0) begin
                    board_d[{spawn_idx_q, 2'b00} +: 4] = (lfsr_q[15:12] == 4'd0) ? 4'd2 : 4'd1;
                    if (spawn_more_q) begin
                        spawn_more_d = 1'b0;
                        spawn_idx_d  = lfsr_q[3:0];
                        spawn_cnt_d  = 4'd0;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else if (spawn_cnt_q == 4'd15) begin
                    state_d = S_CHECK;
                end else begin
                    spawn_idx_d = spawn_idx_q + 4'd1;
                    spawn_cnt_d = spawn_cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                won_d  = won_q | any_win;
                lost_d = lost_q | (board_full & ~has_pair);
                if (from_move_q) move_count_d = move_count_q + 16'd1;
                if (from_init_q)          state_d = S_IDLE;
                else if (won_d || lost_d) state_d = S_OVER;
                else                      state_d = S_WAIT_RELEASE;
                cnt_d       = '0;
                from_move_d = 1'b0;
                from_init_d = 1'b0;
            end
            S_WAIT_RELEASE: begin
                if (dir_valid) begin
                    cnt_d = '0;
                end else begin
                    seen = cnt_q + CNT_W'(1);
                    if (seen == CNT_TARGET) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = seen;
                    end
                end
            end
            default: ;  // S_OVER: wait for new_game
        endcase

        if (new_game) begin
            board_d      = 64'd0;
            won_d        = 1'b0;
            lost_d       = 1'b0;
            move_count_d = 16'd0;
            cnt_d        = '0;
            changed_d    = 1'b0;
            from_move_d  = 1'b0;
            from_init_d  = 1'b0;
            state_d      = S_INIT;
        end

        busy_d = (state_d == S_INIT) || (state_d == S_MOVE) ||
                 (state_d == S_SPAWN) || (state_d == S_CHECK);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT;
            board_q      <= 64'd0;
            lfsr_q       <= LFSR_SEED;
            cnt_q        <= '0;
            dir_prev_q   <= 3'd0;
            dir_lat_q    <= 3'd0;
            line_q       <= 2'd0;
            changed_q    <= 1'b0;
            spawn_idx_q  <= 4'd0;
            spawn_cnt_q  <= 4'd0;
            spawn_more_q <= 1'b0;
            from_move_q  <= 1'b0;
            from_init_q  <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            busy_q       <= 1'b0;
            move_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            dir_prev_q   <= dir_prev_d;
            dir_lat_q    <= dir_lat_d;
            line_q       <= line_d;
            changed_q    <= changed_d;
            spawn_idx_q  <= spawn_idx_d;
            spawn_cnt_q  <= spawn_cnt_d;
            spawn_more_q <= spawn_more_d;
            from_move_q  <= from_move_d;
            from_init_q  <= from_init_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
            busy_q       <= busy_d;
            move_count_q <= move_count_d;
        end
    end

    assign board      = board_q;
    assign busy       = busy_q;
    assign move_done  = (state_q == S_CHECK) && from_move_q;
    assign move_count = move_count_q;
    assign won        = won_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed game sequence; expected results are queued
// when a move is issued and compared once the controller finishes it.
module tb_move_sequencer;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  dir;
    logic        new_game;
    logic        board_load;
    logic [63:0] board_in;
    logic [63:0] board;
    logic        busy;
    logic        move_done;
    logic [15:0] move_count;
    logic        won;
    logic        lost;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;

    typedef struct {
        string       tag;
        logic [63:0] base;
        int          spawns;
        logic [15:0] cnt;
        int          done;
        logic        won;
        logic        lost;
    } exp_t;
    exp_t sb_q[$];

    move_sequencer #(.STABLE_CYCLES(STABLE), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .dir(dir), .new_game(new_game),
        .board_load(board_load), .board_in(board_in), .board(board),
        .busy(busy), .move_done(move_done), .move_count(move_count),
        .won(won), .lost(lost)
    );

    always #5 clk = ~clk;

    // Count cycles with move_done high (a pulse wider than one cycle counts twice)
    always @(negedge clk) if (move_done === 1'b1) done_pulses <= done_pulses + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Board must equal base on base's non-zero cells, plus exactly `spawns` new 1/2 tiles
    task automatic chk_board(input string tag, input logic [63:0] base, input int spawns);
        int         extra;
        bit         ok;
        logic [3:0] bc, ec;
        extra = 0;
        ok    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bc = board[4*k +: 4];
            ec = base[4*k +: 4];
            if (ec != 4'd0) begin
                if (bc !== ec) ok = 1'b0;
            end else if (bc != 4'd0) begin
                extra++;
                if (bc != 4'd1 && bc != 4'd2) ok = 1'b0;
            end
        end
        if (extra != spawns) ok = 1'b0;
        vectors++;
        assert (ok === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: board %h observed, required base %h plus %0d new 1/2 tile(s)",
                   tag, board, base, spawns);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] base, input int spawns,
                            input logic [15:0] cnt, input int done, input logic w, input logic l);
        exp_t e;
        e.tag = tag; e.base = base; e.spawns = spawns; e.cnt = cnt;
        e.done = done; e.won = w; e.lost = l;
        sb_q.push_back(e);
    endtask

    task automatic check_front(input int p0);
        exp_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue, required an entry");
            return;
        end
        e = sb_q.pop_front();
        chk_board({e.tag, "_board"}, e.base, e.spawns);
        chk({e.tag, "_count"}, 64'(move_count), 64'(e.cnt));
        chk({e.tag, "_done"}, 64'(done_pulses - p0), 64'(e.done));
        chk({e.tag, "_won"}, 64'(won), 64'(e.won));
        chk({e.tag, "_lost"}, 64'(lost), 64'(e.lost));
        chk({e.tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Bounded wait for busy to rise and then fall again
    task automatic wait_busy_cycle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        n = 0;
        while (busy !== 1'b0 && n < 80) begin @(negedge clk); n++; end
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    task automatic load_board(input string tag, input logic [63:0] b);
        board_in   = b;
        board_load = 1'b1;
        @(negedge clk);
        board_load = 1'b0;
        chk({tag, "_load"}, board, b);
    endtask

    // Issue a move; optionally keep the direction held (with a stray load) before release
    task automatic do_move(input string tag, input logic [2:0] d, input logic [63:0] base,
                           input int spawns, input logic [15:0] cnt, input int done,
                           input logic w, input logic l, input int hold);
        int p0;
        push_exp(tag, base, spawns, cnt, done, w, l);
        p0  = done_pulses;
        dir = d;
        wait_busy_cycle(tag);
        if (hold > 0) begin
            board_in   = 64'hFFFF_FFFF_FFFF_FFFF;
            board_load = 1'b1;
            @(negedge clk);
            board_load = 1'b0;
            repeat (hold) @(negedge clk);
        end
        dir = 3'd0;
        repeat (STABLE + 4) @(negedge clk);
        check_front(p0);
    endtask

    // While the game is over, direction and load must have no effect
    task automatic idle_probe(input string tag, input logic [2:0] d, input logic [63:0] base,
                              input logic [15:0] cnt);
        int highs;
        highs      = 0;
        dir        = d;
        board_in   = 64'd0;
        board_load = 1'b1;
        repeat (STABLE * 3) begin
            @(negedge clk);
            board_load = 1'b0;
            if (busy === 1'b1) highs++;
        end
        dir = 3'd0;
        chk({tag, "_busy_seen"}, 64'(highs), 64'd0);
        chk_board({tag, "_board"}, base, 1);
        chk({tag, "_count"}, 64'(move_count), 64'(cnt));
    endtask

    task automatic pulse_new_game(input string tag);
        int p0;
        push_exp(tag, 64'd0, 2, 16'd0, 0, 1'b0, 1'b0);
        p0       = done_pulses;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        wait_busy_cycle(tag);
        check_front(p0);
    endtask

    initial begin
        int p0;
        int n;
        rst        = 1'b0;
        dir        = 3'd0;
        new_game   = 1'b0;
        board_load = 1'b0;
        board_in   = 64'd0;
        repeat (3) @(negedge clk);

        chk("rst_board", board, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(move_done), 64'd0);
        chk("rst_count", 64'(move_count), 64'd0);
        chk("rst_won", 64'(won), 64'd0);
        chk("rst_lost", 64'(lost), 64'd0);

        // Release reset: two spawned tiles, back to idle
        push_exp("init", 64'd0, 2, 16'd0, 0, 1'b0, 1'b0);
        p0  = done_pulses;
        rst = 1'b1;
        wait_busy_cycle("init");
        check_front(p0);

        // Row0 [1,1,2,2] left -> [2,3,0,0]
        load_board("pairs", 64'h0000_0000_0000_2211);
        do_move("pairs", 3'd3, 64'h0000_0000_0000_0032, 1, 16'd1, 1, 1'b0, 1'b0, 0);

        // Row0 [1,1,1,1] left -> [2,2,0,0], no double merge
        load_board("quad", 64'h0000_0000_0000_1111);
        do_move("quad", 3'd3, 64'h0000_0000_0000_0022, 1, 16'd2, 1, 1'b0, 1'b0, 0);

        // Column0 [0,1,0,1] down -> [0,0,0,2]
        load_board("col", 64'h0001_0000_0001_0000);
        do_move("col", 3'd2, 64'h0002_0000_0000_0000, 1, 16'd3, 1, 1'b0, 1'b0, 0);

        // No-change move: no spawn, no count, held dir and stray load ignored
        load_board("nochg", 64'h0000_0000_0000_0021);
        do_move("nochg", 3'd3, 64'h0000_0000_0000_0021, 0, 16'd3, 0, 1'b0, 1'b0, 10);

        // Full checkerboard, no-change move: lost is not evaluated
        load_board("checker", 64'h1212_2121_1212_2121);
        do_move("checker", 3'd3, 64'h1212_2121_1212_2121, 0, 16'd3, 0, 1'b0, 1'b0, 0);

        // Near-full board: left fills the last gap with the spawn -> lost
        load_board("lose", 64'hA987_6543_9876_5403);
        do_move("lose", 3'd3, 64'hA987_6543_9876_0543, 1, 16'd4, 1, 1'b0, 1'b1, 10);
        idle_probe("lose_over", 3'd4, 64'hA987_6543_9876_0543, 16'd4);

        pulse_new_game("ng1");

        // Row0 [10,10,0,0] left -> 11 -> won, game over
        load_board("win", 64'h0000_0000_0000_00AA);
        do_move("win", 3'd3, 64'h0000_0000_0000_000B, 1, 16'd1, 1, 1'b1, 1'b0, 10);
        idle_probe("win_over", 3'd4, 64'h0000_0000_0000_000B, 16'd1);

        pulse_new_game("ng2");

        // new_game while a move is in flight restarts cleanly
        load_board("mid", 64'h0000_0000_0000_1111);
        push_exp("mid", 64'd0, 2, 16'd0, 0, 1'b0, 1'b0);
        p0  = done_pulses;
        dir = 3'd3;
        n   = 0;
        while (busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("mid_move_start", 64'(busy), 64'd1);
        @(negedge clk);
        new_game = 1'b1;
        dir      = 3'd0;
        @(negedge clk);
        new_game = 1'b0;
        wait_busy_cycle("mid");
        check_front(p0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
